// File: rtl/tlb_lookup_ctrl.sv
// tlb_lookup_ctrl
//   Lookup/refill controller for a set-associative TLB storage array.
//   It takes one translation request at a time, reads the addressed set and
//   compares all ways. A hit answers straight away and bumps the way's use
//   counter. A miss issues a page-table walk, picks a victim way, writes the
//   refilled entry and then answers.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready, req_vaddr, req_write       translation request
//   resp_valid/ready, resp_paddr, resp_fault    translation response
//   rd_set_index, rd_valid, rd_vpn, rd_ppn, rd_perms, rd_lru_count
//                             storage read port (data returns in the same cycle)
//   wr_en, update_en, lru_update_en             storage write strobes
//   wr_set_index, wr_way, wr_valid, wr_vpn, wr_ppn, wr_perms, wr_lru_count
//   lru_set_index, lru_way    storage entry / use-counter write fields
//   ptw_req_valid/ready, ptw_req_vpn            page-table-walk request
//   ptw_resp_valid, ptw_resp_ppn, ptw_resp_perms, ptw_resp_fault
//                             single-cycle walk result strobe
module tlb_lookup_ctrl #(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_vaddr,
  input  logic                         req_write,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_paddr,
  output logic                         resp_fault,
  output logic [SET_INDEX_BITS-1:0]    rd_set_index,
  input  logic [NUM_WAYS-1:0]          rd_valid,
  input  logic [20*NUM_WAYS-1:0]       rd_vpn,
  input  logic [20*NUM_WAYS-1:0]       rd_ppn,
  input  logic [2*NUM_WAYS-1:0]        rd_perms,
  input  logic [LRU_BITS*NUM_WAYS-1:0] rd_lru_count,
  output logic                         wr_en,
  output logic                         update_en,
  output logic                         lru_update_en,
  output logic [SET_INDEX_BITS-1:0]    wr_set_index,
  output logic [SET_INDEX_BITS-1:0]    lru_set_index,
  output logic [1:0]                   wr_way,
  output logic [1:0]                   lru_way,
  output logic                         wr_valid,
  output logic [19:0]                  wr_vpn,
  output logic [19:0]                  wr_ppn,
  output logic [1:0]                   wr_perms,
  output logic [LRU_BITS-1:0]          wr_lru_count,
  output logic                         ptw_req_valid,
  input  logic                         ptw_req_ready,
  output logic [19:0]                  ptw_req_vpn,
  input  logic                         ptw_resp_valid,
  input  logic [19:0]                  ptw_resp_ppn,
  input  logic [1:0]                   ptw_resp_perms,
  input  logic                         ptw_resp_fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT, S_REFILL, S_RESP
  } state_t;

  // Keeps the index inside the array when fewer sets than 2**SET_INDEX_BITS exist.
  localparam logic [SET_INDEX_BITS-1:0] SET_MASK = SET_INDEX_BITS'(NUM_SETS - 1);

  state_t                    state;
  logic [31:0]               vaddr_q;
  logic                      write_q;
  logic [1:0]                victim_q;
  logic [19:0]               walk_ppn_q;
  logic [1:0]                walk_perms_q;
  logic [31:0]               paddr_q;
  logic                      fault_q;
  logic                      req_ready_q;
  logic                      resp_valid_q;
  logic                      ptw_req_valid_q;

  logic [19:0]               vpn;
  logic [SET_INDEX_BITS-1:0] set_idx;
  logic                      hit;
  logic [1:0]                hit_way;
  logic [19:0]               hit_ppn;
  logic [1:0]                hit_perms;
  logic [LRU_BITS-1:0]       hit_cnt;
  logic                      inv_found;
  logic [1:0]                inv_way;
  logic [1:0]                min_way;
  logic [LRU_BITS-1:0]       min_cnt;
  logic [1:0]                victim_way;
  logic                      lru_bump;
  logic                      refill_fire;

  assign vpn     = vaddr_q[31:12];
  assign set_idx = vpn[SET_INDEX_BITS-1:0] & SET_MASK;

  // Way compare and victim choice; descending loops leave the lowest index.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_vpn[20*w +: 20] == vpn)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (!rd_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = 2'(w);
      end
    end
    // Strict less-than keeps the lowest index on ties.
    min_way = '0;
    min_cnt = rd_lru_count[0 +: LRU_BITS];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (rd_lru_count[LRU_BITS*w +: LRU_BITS] < min_cnt) begin
        min_cnt = rd_lru_count[LRU_BITS*w +: LRU_BITS];
        min_way = 2'(w);
      end
    end
    victim_way = inv_found ? inv_way : min_way;
    hit_ppn   = '0;
    hit_perms = '0;
    hit_cnt   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_way == 2'(w)) begin
        hit_ppn   = rd_ppn[20*w +: 20];
        hit_perms = rd_perms[2*w +: 2];
        hit_cnt   = rd_lru_count[LRU_BITS*w +: LRU_BITS];
      end
    end
  end

  // A saturated counter is left alone because storage would wrap it to zero.
  assign lru_bump    = (state == S_LOOKUP) && hit && (hit_cnt != '1) && !rst;
  assign refill_fire = (state == S_REFILL) && !rst;

  assign rd_set_index  = set_idx;
  assign wr_set_index  = set_idx;
  assign lru_set_index = set_idx;
  assign wr_en         = lru_bump || refill_fire;
  assign update_en     = refill_fire;
  assign lru_update_en = lru_bump;
  assign lru_way       = lru_bump ? hit_way : '0;
  assign wr_way        = refill_fire ? victim_q : (lru_bump ? hit_way : '0);
  assign wr_valid      = refill_fire;
  assign wr_vpn        = refill_fire ? vpn : '0;
  assign wr_ppn        = refill_fire ? walk_ppn_q : '0;
  assign wr_perms      = refill_fire ? walk_perms_q : '0;
  assign wr_lru_count  = refill_fire ? LRU_BITS'(1)
                       : (lru_bump ? hit_cnt + LRU_BITS'(1) : '0);

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_paddr    = paddr_q;
  assign resp_fault    = fault_q;
  assign ptw_req_valid = ptw_req_valid_q;
  assign ptw_req_vpn   = ptw_req_valid_q ? vpn : '0;

  // Handshake outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      ptw_req_valid_q <= 1'b0;
      vaddr_q         <= '0;
      write_q         <= 1'b0;
      victim_q        <= '0;
      walk_ppn_q      <= '0;
      walk_perms_q    <= '0;
      paddr_q         <= '0;
      fault_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            vaddr_q     <= req_vaddr;
            write_q     <= req_write;
            req_ready_q <= 1'b0;
            state       <= S_LOOKUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            paddr_q      <= {hit_ppn, vaddr_q[11:0]};
            fault_q      <= ~hit_perms[write_q];
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end else begin
            victim_q        <= victim_way;
            ptw_req_valid_q <= 1'b1;
            state           <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (ptw_req_ready) begin
            ptw_req_valid_q <= 1'b0;
            state           <= S_WALK_WAIT;
          end
        end
        S_WALK_WAIT: begin
          if (ptw_resp_valid) begin
            if (ptw_resp_fault) begin
              paddr_q      <= '0;
              fault_q      <= 1'b1;
              resp_valid_q <= 1'b1;
              state        <= S_RESP;
            end else begin
              walk_ppn_q   <= ptw_resp_ppn;
              walk_perms_q <= ptw_resp_perms;
              state        <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          paddr_q      <= {walk_ppn_q, vaddr_q[11:0]};
          fault_q      <= ~walk_perms_q[write_q];
          resp_valid_q <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Testbench for tlb_lookup_ctrl: a behavioural storage array driven by the
// DUT, an independent reference copy of the TLB contents, directed scenarios
// and randomized translation traffic.
module tb_tlb_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_paddr;
  logic [3:0]  rd_set_index, wr_set_index, lru_set_index;
  logic [3:0]  rd_valid;
  logic [79:0] rd_vpn, rd_ppn;
  logic [7:0]  rd_perms;
  logic [15:0] rd_lru_count;
  logic        wr_en, update_en, lru_update_en, wr_valid;
  logic [1:0]  wr_way, lru_way, wr_perms;
  logic [19:0] wr_vpn, wr_ppn;
  logic [3:0]  wr_lru_count;
  logic        ptw_req_valid, ptw_req_ready;
  logic [19:0] ptw_req_vpn;
  logic        ptw_resp_valid, ptw_resp_fault;
  logic [19:0] ptw_resp_ppn;
  logic [1:0]  ptw_resp_perms;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tlb_lookup_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr), .resp_fault(resp_fault),
    .rd_set_index(rd_set_index), .rd_valid(rd_valid), .rd_vpn(rd_vpn), .rd_ppn(rd_ppn),
    .rd_perms(rd_perms), .rd_lru_count(rd_lru_count),
    .wr_en(wr_en), .update_en(update_en), .lru_update_en(lru_update_en),
    .wr_set_index(wr_set_index), .lru_set_index(lru_set_index),
    .wr_way(wr_way), .lru_way(lru_way), .wr_valid(wr_valid), .wr_vpn(wr_vpn), .wr_ppn(wr_ppn),
    .wr_perms(wr_perms), .wr_lru_count(wr_lru_count),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
    .ptw_resp_perms(ptw_resp_perms), .ptw_resp_fault(ptw_resp_fault)
  );

  // Storage array as seen by the DUT.
  logic        st_valid [16][4];
  logic [19:0] st_vpn   [16][4];
  logic [19:0] st_ppn   [16][4];
  logic [1:0]  st_perms [16][4];
  logic [3:0]  st_lru   [16][4];

  // Reference copy of what the TLB should hold.
  logic        ref_valid [16][4];
  logic [19:0] ref_vpn   [16][4];
  logic [19:0] ref_ppn   [16][4];
  logic [1:0]  ref_perms [16][4];
  logic [3:0]  ref_lru   [16][4];

  logic        clr, poke_en;
  int          poke_set, poke_way;
  logic [19:0] poke_vpn, poke_ppn;
  logic [1:0]  poke_perms;
  logic [3:0]  poke_lru;

  always_comb begin
    rd_valid = '0; rd_vpn = '0; rd_ppn = '0; rd_perms = '0; rd_lru_count = '0;
    for (int w = 0; w < 4; w++) begin
      rd_valid[w]           = st_valid[rd_set_index][w];
      rd_vpn[20*w +: 20]    = st_vpn[rd_set_index][w];
      rd_ppn[20*w +: 20]    = st_ppn[rd_set_index][w];
      rd_perms[2*w +: 2]    = st_perms[rd_set_index][w];
      rd_lru_count[4*w +: 4] = st_lru[rd_set_index][w];
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 4; w++) begin
          st_valid[s][w] <= 1'b0; st_vpn[s][w] <= '0; st_ppn[s][w] <= '0;
          st_perms[s][w] <= '0;   st_lru[s][w] <= '0;
        end
    end else begin
      if (poke_en) begin
        st_valid[poke_set][poke_way] <= 1'b1;
        st_vpn[poke_set][poke_way]   <= poke_vpn;
        st_ppn[poke_set][poke_way]   <= poke_ppn;
        st_perms[poke_set][poke_way] <= poke_perms;
        st_lru[poke_set][poke_way]   <= poke_lru;
      end
      if (wr_en && update_en) begin
        st_valid[wr_set_index][wr_way] <= wr_valid;
        st_vpn[wr_set_index][wr_way]   <= wr_vpn;
        st_ppn[wr_set_index][wr_way]   <= wr_ppn;
        st_perms[wr_set_index][wr_way] <= wr_perms;
        st_lru[wr_set_index][wr_way]   <= wr_lru_count;
      end
      if (wr_en && lru_update_en)
        st_lru[lru_set_index][lru_way] <= wr_lru_count;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (update_en || lru_update_en)
      chk("strobe_excl", 64'(update_en & lru_update_en), 64'(0));

  task automatic cmp_set(input int s);
    for (int w = 0; w < 4; w++)
      chk($sformatf("entry[%0d][%0d]", s, w),
          64'({st_valid[s][w], st_vpn[s][w], st_ppn[s][w], st_perms[s][w], st_lru[s][w]}),
          64'({ref_valid[s][w], ref_vpn[s][w], ref_ppn[s][w], ref_perms[s][w], ref_lru[s][w]}));
  endtask

  task automatic poke(input int s, input int w, input logic [19:0] vpn, input logic [19:0] ppn,
                      input logic [1:0] perms, input logic [3:0] lru);
    poke_set = s; poke_way = w; poke_vpn = vpn; poke_ppn = ppn;
    poke_perms = perms; poke_lru = lru; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_valid[s][w] = 1'b1; ref_vpn[s][w] = vpn; ref_ppn[s][w] = ppn;
    ref_perms[s][w] = perms; ref_lru[s][w] = lru;
  endtask

  // One full translation, starting and ending on a negedge with the DUT idle.
  task automatic do_txn(input logic [31:0] va, input logic wr, input int wlat,
                        input logic [19:0] wppn, input logic [1:0] wperms, input logic wfault);
    logic [19:0] vpn;
    int          s, hw, vic, n;
    bit          hit, bump;
    logic [31:0] ep;
    logic        ef;
    vpn = va[31:12];
    s = int'(vpn[3:0]);
    hit = 0; hw = 0; bump = 0; vic = -1;
    for (int w = 0; w < 4; w++)
      if (!hit && ref_valid[s][w] && ref_vpn[s][w] == vpn) begin hit = 1; hw = w; end
    if (hit) begin
      ep   = {ref_ppn[s][hw], va[11:0]};
      ef   = !ref_perms[s][hw][wr];
      bump = (ref_lru[s][hw] != 4'hF);
    end else begin
      for (int w = 0; w < 4; w++) if (vic < 0 && !ref_valid[s][w]) vic = w;
      if (vic < 0) begin
        vic = 0;
        for (int w = 1; w < 4; w++) if (ref_lru[s][w] < ref_lru[s][vic]) vic = w;
      end
      ep = wfault ? 32'h0 : {wppn, va[11:0]};
      ef = wfault ? 1'b1 : !wperms[wr];
    end

    req_valid = 1'b1; req_vaddr = va; req_write = wr;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", 64'(req_ready), 64'(1));
    if (!req_ready) begin req_valid = 1'b0; return; end

    @(negedge clk);
    req_valid = 1'b0; req_vaddr = $urandom; req_write = 1'($urandom);
    chk("lookup_req_ready", 64'(req_ready), 64'(0));
    chk("rd_set", 64'(rd_set_index), 64'(s));
    chk("lru_pulse", 64'(lru_update_en), 64'(hit && bump));
    chk("lookup_wr_en", 64'(wr_en), 64'(hit && bump));
    chk("lookup_update_en", 64'(update_en), 64'(0));
    chk("lookup_ptw", 64'(ptw_req_valid), 64'(0));
    if (hit && bump) begin
      chk("lru_way", 64'(lru_way), 64'(hw));
      chk("lru_set", 64'(lru_set_index), 64'(s));
      chk("lru_count", 64'(wr_lru_count), 64'(ref_lru[s][hw] + 4'd1));
    end
    if (hit) begin
      ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'($urandom); ptw_resp_fault = 1'($urandom);
    end

    @(negedge clk);
    ptw_resp_valid = 1'b0;
    if (!hit) begin
      chk("ptw_req_valid", 64'(ptw_req_valid), 64'(1));
      chk("ptw_req_vpn", 64'(ptw_req_vpn), 64'(vpn));
      chk("early_resp", 64'(resp_valid), 64'(0));
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        chk("ptw_hold_valid", 64'(ptw_req_valid), 64'(1));
        chk("ptw_hold_vpn", 64'(ptw_req_vpn), 64'(vpn));
      end
      ptw_req_ready = 1'b1;
      @(negedge clk);
      ptw_req_ready = 1'b0;
      chk("ptw_req_drop", 64'(ptw_req_valid), 64'(0));
      repeat (wlat) begin @(negedge clk); chk("wait_resp", 64'(resp_valid), 64'(0)); end
      ptw_resp_valid = 1'b1; ptw_resp_ppn = wppn; ptw_resp_perms = wperms; ptw_resp_fault = wfault;
      @(negedge clk);
      ptw_resp_valid = 1'b0;
      chk("refill_update_en", 64'(update_en), 64'(!wfault));
      chk("refill_wr_en", 64'(wr_en), 64'(!wfault));
      chk("refill_lru_en", 64'(lru_update_en), 64'(0));
      if (!wfault) begin
        chk("refill_way", 64'(wr_way), 64'(vic));
        chk("refill_set", 64'(wr_set_index), 64'(s));
        chk("refill_fields", 64'({wr_valid, wr_vpn, wr_ppn, wr_perms, wr_lru_count}),
            64'({1'b1, vpn, wppn, wperms, 4'd1}));
        chk("refill_resp", 64'(resp_valid), 64'(0));
        @(negedge clk);
      end
    end
    else chk("hit_ptw", 64'(ptw_req_valid), 64'(0));

    chk("resp_valid", 64'(resp_valid), 64'(1));
    chk("resp_paddr", 64'(resp_paddr), 64'(ep));
    chk("resp_fault", 64'(resp_fault), 64'(ef));
    n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      chk("resp_hold", 64'({resp_valid, resp_fault, resp_paddr}), 64'({1'b1, ef, ep}));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 64'(resp_valid), 64'(0));
    chk("ready_back", 64'(req_ready), 64'(1));

    if (hit && bump) ref_lru[s][hw] = ref_lru[s][hw] + 4'd1;
    if (!hit && !wfault) begin
      ref_valid[s][vic] = 1'b1; ref_vpn[s][vic] = vpn; ref_ppn[s][vic] = wppn;
      ref_perms[s][vic] = wperms; ref_lru[s][vic] = 4'd1;
    end
    cmp_set(s);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] rvpn;
    rst = 1'b1; clr = 1'b1; poke_en = 1'b0;
    poke_set = 0; poke_way = 0; poke_vpn = '0; poke_ppn = '0; poke_perms = '0; poke_lru = '0;
    req_valid = 1'b0; req_vaddr = '0; req_write = 1'b0; resp_ready = 1'b0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_ppn = '0;
    ptw_resp_perms = '0; ptw_resp_fault = 1'b0;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        ref_valid[s][w] = 1'b0; ref_vpn[s][w] = '0; ref_ppn[s][w] = '0;
        ref_perms[s][w] = '0;   ref_lru[s][w] = '0;
      end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_ptw_valid", 64'(ptw_req_valid), 64'(0));
    chk("rst_set_index", 64'(rd_set_index), 64'(0));
    chk("rst_strobes", 64'({wr_en, update_en, lru_update_en}), 64'(0));
    chk("rst_resp_data", 64'({resp_fault, resp_paddr}), 64'(0));
    clr = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'(1));

    // Cold miss, then hit, then store permission fault on the same page.
    do_txn(32'h0001_2345, 1'b0, 2, 20'hABCDE, 2'b01, 1'b0);
    do_txn(32'h0001_2345, 1'b0, 0, 20'h0, 2'b00, 1'b0);
    do_txn(32'h0001_2345, 1'b1, 0, 20'h0, 2'b00, 1'b0);
    // Walk fault: no refill.
    do_txn(32'h0003_3ABC, 1'b0, 1, 20'h11111, 2'b11, 1'b1);

    // Victim choice in a full set: minimum count, lowest index on ties.
    poke(5, 0, 20'h00005, 20'h50000, 2'b11, 4'd3);
    poke(5, 1, 20'h00015, 20'h50001, 2'b11, 4'd1);
    poke(5, 2, 20'h00025, 20'h50002, 2'b11, 4'd1);
    poke(5, 3, 20'h00035, 20'h50003, 2'b11, 4'd2);
    do_txn(32'h0004_5010, 1'b0, 0, 20'h22222, 2'b11, 1'b0);
    chk("victim_way1_vpn", 64'(st_vpn[5][1]), 64'(20'h00045));

    // Saturated counter is not bumped.
    poke(5, 0, 20'h00005, 20'h33333, 2'b11, 4'hF);
    do_txn(32'h0000_5ABC, 1'b0, 0, 20'h0, 2'b00, 1'b0);

    // Reset while waiting for the walk; the late result must be ignored.
    req_valid = 1'b1; req_vaddr = 32'h0007_7000; req_write = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midwalk_ptw_valid", 64'(ptw_req_valid), 64'(1));
    ptw_req_ready = 1'b1;
    @(negedge clk);
    ptw_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midwalk_rst_hs", 64'({req_ready, resp_valid, ptw_req_valid, update_en}), 64'(0));
    rst = 1'b0;
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'h77777; ptw_resp_perms = 2'b11; ptw_resp_fault = 1'b0;
    @(negedge clk);
    ptw_resp_valid = 1'b0;
    chk("midwalk_update_en", 64'(update_en), 64'(0));
    chk("midwalk_resp_valid", 64'(resp_valid), 64'(0));
    chk("midwalk_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    chk("midwalk_late_update", 64'({update_en, resp_valid}), 64'(0));
    cmp_set(7);

    // Random traffic over a small page pool so hits, refills and evictions mix.
    for (int i = 0; i < 80; i++) begin
      rvpn = {12'h000, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 3))};
      do_txn({rvpn, 12'($urandom)}, 1'($urandom), $urandom_range(0, 3),
             20'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlb_lookup_ctrl.md
# tlb_lookup_ctrl

Lookup/refill controller that drives the TLB storage array. It accepts one translation request at a time, reads the addressed set, and compares all ways. On a hit it returns the physical address and bumps the way's LRU count. On a miss it issues a page-table-walk request, selects a victim way, writes the refilled entry and then responds. It sits between the core's address-translation port and the storage block, acting as the sole initiator on the storage read, write and LRU-update interfaces.

## Interface
- NUM_SETS, 16, sets in storage
- NUM_WAYS, 4, ways per set; way index is fixed at 2 bits
- SET_INDEX_BITS, 4, log2(NUM_SETS)
- LRU_BITS, 4, width of per-way use counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid / req_ready  in / out  1 / 1  translation request handshake
- req_vaddr  in  32  virtual address; VPN = [31:12], offset = [11:0]
- req_write  in  1  1 = store access (needs perms[1]); 0 = load (needs perms[0])
- resp_valid / resp_ready  out / in  1 / 1  response handshake
- resp_paddr  out  32  {PPN, offset}
- resp_fault  out  1  walk fault or permission violation
- rd_set_index  out  SET_INDEX_BITS  storage read set
- rd_valid  in  NUM_WAYS  per-way valid bits
- rd_vpn, rd_ppn  in  20*NUM_WAYS each  way w at [20w+19:20w]
- rd_perms  in  2*NUM_WAYS  way w at [2w+1:2w]
- rd_lru_count  in  LRU_BITS*NUM_WAYS  per-way use counters
- wr_en, update_en, lru_update_en  out  1 each  storage strobes
- wr_set_index, lru_set_index  out  SET_INDEX_BITS
- wr_way, lru_way  out  2
- wr_valid  out  1
- wr_vpn, wr_ppn  out  20 each
- wr_perms  out  2
- wr_lru_count  out  LRU_BITS
- ptw_req_valid / ptw_req_ready  out / in  1 / 1  walk request handshake
- ptw_req_vpn  out  20
- ptw_resp_valid  in  1  single-cycle walk result strobe; no backpressure
- ptw_resp_ppn  in  20
- ptw_resp_perms  in  2
- ptw_resp_fault  in  1

## Operation
- FSM states: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register vaddr and req_write, then go to LOOKUP.
- Set index is VPN[SET_INDEX_BITS-1:0] of the registered address. rd_set_index, wr_set_index and lru_set_index all carry it in every state.
- LOOKUP (one cycle): hit when rd_valid[w] is set and rd_vpn[w] == VPN. Multiple matches resolve to the lowest w.
  - Hit:
    - Pulse wr_en=1 and lru_update_en=1 with lru_way=w. Suppress the pulse if rd_lru_count[w] is all ones (saturation; storage wraps otherwise).
    - Register paddr = {rd_ppn[w], offset}.
    - fault = the required perms bit is 0. LRU is bumped even on a permission fault.
    - Go to RESP.
  - Miss:
    - Latch the victim: the lowest-index invalid way. If all ways are valid, the way with the minimum rd_lru_count; ties go to the lowest index.
    - Go to WALK_REQ.
- WALK_REQ: ptw_req_valid=1, ptw_req_vpn=VPN, held stable until ptw_req_ready, then go to WALK_WAIT.
- WALK_WAIT: wait for ptw_resp_valid.
  - If ptw_resp_fault: fault=1, paddr=0, no refill, go to RESP.
  - Else: latch ppn/perms and go to REFILL.
- REFILL (one cycle):
  - wr_en=1, update_en=1, wr_way=victim, wr_valid=1, wr_vpn=VPN, wr_ppn/wr_perms from the walk, wr_lru_count=1.
  - fault = the required perms bit is 0. paddr={ppn, offset}.
  - Go to RESP.
- RESP: resp_valid=1 with resp_paddr and resp_fault held stable until resp_ready, then go to IDLE.
- update_en and lru_update_en are never asserted in the same cycle.

## Timing
- Reset values: IDLE. All outputs are 0 (req_ready=0, resp_valid=0, ptw_req_valid=0, all storage strobes 0), except rd_set_index, which is 0.
- Hit latency: request accepted at cycle 0, LOOKUP at cycle 1 (LRU pulse), resp_valid at cycle 2. With resp_ready held high, back-to-back throughput is one request per 3 cycles.
- Miss latency: accepted at cycle 0, LOOKUP 1, ptw_req_valid 2. With walk response at cycle k: REFILL k+1, resp_valid k+2.
- req_ready is 1 only in IDLE.
- A ptw_resp_valid arriving outside WALK_WAIT is ignored.
- Storage writes land at the clock edge ending REFILL. A new request to the same VPN accepted on the cycle after RESP hits.
- rst asserted in any state:
  - Next state is IDLE and all handshakes deassert next cycle.
  - Any outstanding walk is abandoned and its late response is ignored.
  - No storage write is issued.

## Test plan
- Cold miss: after reset, req vaddr=0x0001_2345 load. Expect ptw_req_vpn=0x00012 at cycle 2. Respond with ppn=0xABCDE, perms=2'b01. Expect REFILL to set 2, way 0, wr_lru_count=1, then resp_paddr=0xABCD_E345, fault=0.
- Hit: repeat the same vaddr. Expect resp_valid at cycle 2, lru_update_en pulse with set 2 / way 0, and no ptw_req_valid.
- Permission fault: store to the same vaddr with perms=01. Expect a hit with resp_fault=1. Separately, a walk returning ptw_resp_fault=1 gives resp_fault=1 and no update_en.
- Victim selection: fill set 5 with VPNs 0x00005/0x00015/0x00025/0x00035, LRU counts 3/1/1/2. Miss on VPN 0x00045 replaces way 1.
- LRU saturation: way count = 4'hF, then hit. Expect no lru_update_en pulse; count stays 0xF.
- Reset mid-walk: assert rst in WALK_WAIT, then drive ptw_resp_valid. Expect no update_en, resp_valid=0, req_ready=1 one cycle after rst deasserts.
